mux_nt1_rr: RTL

//   Parametrised N:1 channel multiplexer with a registered output and valid/ready handshake.

---
 rtl/mux_nt1_rr_pkg.sv | 12 +
 rtl/mux_nt1_rr_rr_arbiter.sv | 28 ++
 rtl/mux_nt1_rr.sv | 92 +++++++++
 3 files changed

// File: rtl/mux_nt1_rr_pkg.sv
// Shared constants and mode encoding for the N:1 handshake multiplexer.
package mux_pkg;

  localparam int unsigned MUX_N     = 4;
  localparam int unsigned MUX_WIDTH = 8;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_nt1_rr_rr_arbiter.sv
// Combinational rotate-priority search: first asserted req at ptr, ptr+1, ... (mod N).
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int unsigned idx;

  // Scan farthest offset first so the last hit (closest to ptr) wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = (32'(ptr) + k - 1) % N;
      if (req[SELW'(idx)]) begin
        gnt_idx = SELW'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nt1_rr.sv
// N:1 channel multiplexer with registered output, valid/ready handshake,
// and fixed-select or round-robin channel selection.
module mux_nt1_rr
  import mux_pkg::*;
#(
  parameter  int unsigned N     = MUX_N,
  parameter  int unsigned WIDTH = MUX_WIDTH,
  localparam int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    Sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   F,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
);

  logic [WIDTH-1:0] f_q;
  logic             valid_q;
  logic [SELW-1:0]  chan_q;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [SELW-1:0]  arb_idx;
  logic             arb_any;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_ok;
  logic             can_load;
  logic             xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign can_load = !valid_q || out_ready;

  always_comb begin
    gnt_idx  = '0;
    gnt_ok   = 1'b0;
    in_ready = '0;
    if (mode_e'(mode) == MODE_RR) begin
      gnt_idx = arb_idx;
      gnt_ok  = arb_any;
    end else begin
      gnt_idx = Sel;
      gnt_ok  = (32'(Sel) < N);
    end
    // While in reset valid_q is cleared, so rst_n must gate ready explicitly.
    if (rst_n && gnt_ok && can_load) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  assign xfer = in_valid[gnt_idx] && in_ready[gnt_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && mode_e'(mode) == MODE_RR) begin
      ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        f_q     <= in_data[gnt_idx*WIDTH +: WIDTH];
        chan_q  <= gnt_idx;
        valid_q <= 1'b1;
      end else if (can_load) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign F         = f_q;
  assign out_valid = valid_q;
  assign out_chan  = chan_q;

endmodule
